// File: rtl/instr_mem_responder_pkg.sv
// Shared fetch-interface definitions: field widths, response constants, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_mem_responder_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;
    // Wide enough for the largest legal access latency (15).
    localparam int LAT_W   = 4;

    // Returned in place of data whenever the address check fails.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    // Word number of a byte address, kept at full width so that addresses
    // beyond the array can still be recognised as out of range.
    function automatic logic [ADDR_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
        return {2'b00, addr[ADDR_W-1:2]};
    endfunction

endpackage

// File: rtl/instr_mem_responder_if.sv
// Instruction-fetch request/response bundle between fetch unit and memory.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the request and the response channel.
// Ports: req_valid/req_ready/req_addr (fetch -> mem), resp_valid/resp_ready/
//        resp_instr/resp_err/resp_last (mem -> fetch).
interface instr_mem_responder_if;
    import instr_mem_responder_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic [ADDR_W-1:0]  req_addr;
    logic               resp_valid;
    logic               resp_ready;
    logic [INSTR_W-1:0] resp_instr;
    logic               resp_err;
    logic               resp_last;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_instr, resp_err, resp_last
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_instr, resp_err, resp_last
    );

endinterface

// File: rtl/instr_mem_responder_imem_array.sv
// Program store: single-port RAM, synchronous write, registered read on re.
// Latency: rdata valid the cycle after the edge that samples re; holds otherwise.
// Backpressure: none; a write and a read of the same word on one edge return old data.
// Ports: clk; we/waddr/wdata write port; re/raddr read request; rdata read data.
module instr_mem_responder_imem_array #(
    parameter int    DEPTH_WORDS = 256,
    parameter string INIT_FILE   = ""
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
    input  logic [31:0]                    wdata,
    input  logic                           re,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
    output logic [31:0]                    rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    // Output register only moves when a read is requested, so the response
    // word stays stable while the requester stalls.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_responder.sv
// Memory-side responder for instruction fetch: one outstanding request, checked read.
// Latency: resp_valid rises LATENCY cycles after the accept edge.
// Backpressure: response held stable until resp_ready; req_ready low from accept to handshake and during a load.
// Ports: clk, reset (sync, active high); bus = fetch request/response channel;
//        load_en/load_word_addr/load_data program write; prog_words length; done sticky completion.
module instr_mem_responder
    import instr_mem_responder_pkg::*;
#(
    parameter int    DEPTH_WORDS = 256,
    parameter int    LATENCY     = 2,
    parameter string INIT_FILE   = "",
    parameter int    INIT_WORDS  = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    instr_mem_responder_if.slave           bus,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_word_addr,
    input  logic [INSTR_W-1:0]             load_data,
    output logic [$clog2(DEPTH_WORDS):0]   prog_words,
    output logic                           done
);

    localparam int               IDX_W       = $clog2(DEPTH_WORDS);
    localparam int               PW_W        = IDX_W + 1;
    localparam logic [LAT_W-1:0] LAT_M1      = LAT_W'(LATENCY - 1);
    localparam logic             DIRECT_RESP = (LATENCY == 1);

    state_e             state_q, state_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               err_q, err_d;
    logic               last_q, last_d;
    logic               done_q, done_d;
    logic [PW_W-1:0]    prog_words_q, prog_words_d;

    logic               req_ready_c;
    logic               accept_c;
    logic               rd_en_c;
    logic [ADDR_W-1:0]  rd_addr_c;
    logic [ADDR_W-1:0]  rd_word_c;
    logic [ADDR_W-1:0]  pw_ext_c;
    logic               chk_err_c;
    logic               chk_last_c;
    logic [PW_W-1:0]    load_len_c;
    logic               resp_vld_c;
    logic [INSTR_W-1:0] rdata;

    instr_mem_responder_imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_imem (
        .clk   (clk),
        .we    (load_en),
        .waddr (load_word_addr),
        .wdata (load_data),
        .re    (rd_en_c),
        .raddr (rd_addr_c[IDX_W+1:2]),
        .rdata (rdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            err_q        <= 1'b0;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
            prog_words_q <= PW_W'(INIT_WORDS);
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            err_q        <= err_d;
            last_q       <= last_d;
            done_q       <= done_d;
            prog_words_q <= prog_words_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        // A load in IDLE takes the cycle; the request waits.
        req_ready_c = (state_q == S_IDLE) && !load_en && !reset;
        accept_c    = req_ready_c && bus.req_valid;

        // With LATENCY==1 the read happens on the accept edge, so the live
        // request address is used instead of the latched one.
        rd_addr_c = (state_q == S_IDLE) ? bus.req_addr : addr_q;
        rd_en_c   = !reset && ((accept_c && DIRECT_RESP) ||
                               (state_q == S_WAIT && cnt_q == '0));

        // Full-width compare: high address bits are never truncated away.
        rd_word_c  = word_index(rd_addr_c);
        pw_ext_c   = ADDR_W'(prog_words_q);
        chk_err_c  = (rd_addr_c[1:0] != 2'b00) || (rd_word_c >= pw_ext_c);
        chk_last_c = !chk_err_c && (rd_word_c == pw_ext_c - ADDR_W'(1));

        load_len_c = PW_W'(load_word_addr) + PW_W'(1);

        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        err_d        = err_q;
        last_d       = last_q;
        done_d       = done_q;
        prog_words_d = prog_words_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    addr_d  = bus.req_addr;
                    cnt_d   = LAT_M1;
                    state_d = DIRECT_RESP ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                    if (last_q) begin
                        done_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Check result is captured alongside the RAM read so the response
        // fields all describe the same access.
        if (rd_en_c) begin
            err_d  = chk_err_c;
            last_d = chk_last_c;
        end

        if (load_en && (load_len_c > prog_words_q)) begin
            prog_words_d = load_len_c;
        end
    end

    // Outputs
    always_comb begin
        resp_vld_c     = (state_q == S_RESP) && !reset;
        bus.req_ready  = req_ready_c;
        bus.resp_valid = resp_vld_c;
        bus.resp_err   = resp_vld_c && err_q;
        bus.resp_last  = resp_vld_c && last_q;
        bus.resp_instr = '0;
        if (resp_vld_c) begin
            bus.resp_instr = err_q ? NOP_INSTR : rdata;
        end
        prog_words = prog_words_q;
        done       = done_q;
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
module tb_instr_mem_responder;
    import instr_mem_responder_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instr_mem_responder_if b2();
    instr_mem_responder_if b1();

    logic        ld_en2, ld_en1;
    logic [7:0]  ld_addr2, ld_addr1;
    logic [31:0] ld_data2, ld_data1;
    logic [8:0]  pw2, pw1;
    logic        done2, done1;

    instr_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .INIT_FILE(""), .INIT_WORDS(0)) dut2 (
        .clk(clk), .reset(reset), .bus(b2.slave), .load_en(ld_en2), .load_word_addr(ld_addr2),
        .load_data(ld_data2), .prog_words(pw2), .done(done2));

    instr_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1), .INIT_FILE(""), .INIT_WORDS(0)) dut1 (
        .clk(clk), .reset(reset), .bus(b1.slave), .load_en(ld_en1), .load_word_addr(ld_addr1),
        .load_data(ld_data1), .prog_words(pw1), .done(done1));

    int checks = 0;
    int errors = 0;

    // Reference model: plain memory image, program length and done flag per instance
    // (index 0 = LATENCY 2 instance, index 1 = LATENCY 1 instance).
    logic [31:0] mem_m [2][256];
    int          pw_m [2];
    bit          done_m [2];
    logic [31:0] prog [4];

    function automatic void model_load(input int inst, input int idx, input logic [31:0] d);
        mem_m[inst][idx] = d;
        if (idx + 1 > pw_m[inst]) pw_m[inst] = idx + 1;
    endfunction

    function automatic void model_read(input int inst, input logic [31:0] a,
                                       output logic [31:0] ins, output logic e, output logic l);
        longint unsigned w;
        w = longint'(a / 4);
        if ((a % 4) != 0 || w >= longint'(pw_m[inst])) begin
            ins = 32'h00000013; e = 1'b1; l = 1'b0;
        end else begin
            ins = mem_m[inst][w]; e = 1'b0; l = (w == longint'(pw_m[inst] - 1));
        end
    endfunction

    task automatic load2(input int idx, input logic [31:0] d);
        ld_en2 = 1'b1; ld_addr2 = 8'(idx); ld_data2 = d;
        @(posedge clk); #1;
        ld_en2 = 1'b0;
        model_load(0, idx, d);
    endtask

    task automatic load1(input int idx, input logic [31:0] d);
        ld_en1 = 1'b1; ld_addr1 = 8'(idx); ld_data1 = d;
        @(posedge clk); #1;
        ld_en1 = 1'b0;
        model_load(1, idx, d);
    endtask

    // Drives one fetch on the LATENCY-2 instance with resp_ready high at the
    // response; lat = edges from accept to resp_valid, -1 if a bound expired.
    task automatic fetch2(input logic [31:0] a, output logic [31:0] ins,
                          output logic e, output logic l, output int lat);
        int n;
        ins = '0; e = 1'b0; l = 1'b0;
        b2.req_valid = 1'b1; b2.req_addr = a; b2.resp_ready = 1'b0;
        #1; n = 0;
        while (!b2.req_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!b2.req_ready) begin b2.req_valid = 1'b0; lat = -1; return; end
        @(posedge clk); #1;
        b2.req_valid = 1'b0;
        lat = 0;
        while (!b2.resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        if (!b2.resp_valid) begin lat = -1; return; end
        ins = b2.resp_instr; e = b2.resp_err; l = b2.resp_last;
        b2.resp_ready = 1'b1;
        @(posedge clk); #1;
        b2.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (b2.req_ready !== 1'b0 || b1.req_ready !== 1'b0) begin errors++;
            $display("FAIL reset_req_ready: got %b/%b exp 0/0", b2.req_ready, b1.req_ready); end
        checks++; if ({b2.resp_valid, b2.resp_err, b2.resp_last, done2} !== 4'b0000) begin errors++;
            $display("FAIL reset_flags: got %b exp 0000", {b2.resp_valid, b2.resp_err, b2.resp_last, done2}); end
        checks++; if (b2.resp_instr !== 32'h0) begin errors++;
            $display("FAIL reset_instr: got %h exp 0", b2.resp_instr); end
        checks++; if (pw2 !== 9'd0 || pw1 !== 9'd0) begin errors++;
            $display("FAIL reset_prog_words: got %0d/%0d exp 0", pw2, pw1); end
        pw_m[0] = 0; pw_m[1] = 0; done_m[0] = 0; done_m[1] = 0;
        reset = 1'b0;
        #1;
        checks++; if (b2.req_ready !== 1'b1 || b1.req_ready !== 1'b1) begin errors++;
            $display("FAIL reset_release_ready: got %b/%b exp 1/1", b2.req_ready, b1.req_ready); end
    endtask

    task automatic test_load();
        for (int i = 0; i < 4; i++) load2(i, prog[i]);
        checks++; if (pw2 !== 9'(pw_m[0])) begin errors++;
            $display("FAIL load_prog_words: got %0d exp %0d", pw2, pw_m[0]); end
    endtask

    task automatic test_misaligned();
        logic [31:0] ins, ei; logic e, l, ee, el; int lat;
        model_read(0, 32'h6, ei, ee, el);
        fetch2(32'h6, ins, e, l, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL misaligned_latency: got %0d exp 2", lat); end
        checks++; if ({ins, e, l} !== {ei, ee, el}) begin errors++;
            $display("FAIL misaligned_resp: got %h/%b/%b exp %h/%b/%b", ins, e, l, ei, ee, el); end
        checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL misaligned_done: got %b exp 0", done2); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] ins, ei; logic e, l, ee, el; int lat;
        model_read(0, 32'h10, ei, ee, el);
        fetch2(32'h10, ins, e, l, lat);
        checks++; if ({ins, e, l} !== {ei, ee, el} || lat !== 2) begin errors++;
            $display("FAIL oor_resp: got %h/%b/%b lat %0d exp %h/%b/%b lat 2", ins, e, l, lat, ei, ee, el); end
        checks++; if (pw2 !== 9'(pw_m[0])) begin errors++;
            $display("FAIL oor_prog_words: got %0d exp %0d", pw2, pw_m[0]); end
    endtask

    task automatic test_program();
        logic [31:0] ins, ei; logic e, l, ee, el; int lat;
        for (int i = 0; i < 4; i++) begin
            model_read(0, 32'(i * 4), ei, ee, el);
            fetch2(32'(i * 4), ins, e, l, lat);
            if (el) done_m[0] = 1;
            checks++; if (lat !== 2) begin errors++; $display("FAIL prog_latency[%0d]: got %0d exp 2", i, lat); end
            checks++; if ({ins, e, l} !== {ei, ee, el}) begin errors++;
                $display("FAIL prog_resp[%0d]: got %h/%b/%b exp %h/%b/%b", i, ins, e, l, ei, ee, el); end
            checks++; if (done2 !== done_m[0]) begin errors++;
                $display("FAIL prog_done[%0d]: got %b exp %b", i, done2, done_m[0]); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] ei; logic ee, el;
        model_read(0, 32'h4, ei, ee, el);
        b2.req_valid = 1'b1; b2.req_addr = 32'h4; b2.resp_ready = 1'b0;
        #1;
        checks++; if (b2.req_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_in: got %b exp 1", b2.req_ready); end
        @(posedge clk); #1;
        b2.req_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (b2.resp_valid !== 1'b1 || b2.resp_instr !== ei) begin errors++;
            $display("FAIL stall_first: got %b/%h exp 1/%h", b2.resp_valid, b2.resp_instr, ei); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++; if ({b2.resp_valid, b2.req_ready, b2.resp_instr} !== {1'b1, 1'b0, ei}) begin errors++;
                $display("FAIL stall_hold[%0d]: got v%b r%b %h exp v1 r0 %h", k, b2.resp_valid, b2.req_ready, b2.resp_instr, ei); end
        end
        b2.resp_ready = 1'b1;
        @(posedge clk); #1;
        b2.resp_ready = 1'b0;
        checks++; if (b2.resp_valid !== 1'b0 || b2.req_ready !== 1'b1) begin errors++;
            $display("FAIL stall_release: got v%b r%b exp v0 r1", b2.resp_valid, b2.req_ready); end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] ins, ei, nd; logic e, l, ee, el; int lat; bit seen;
        b2.req_valid = 1'b1; b2.req_addr = 32'h0;
        @(posedge clk); #1;
        b2.req_valid = 1'b0;
        checks++; if (b2.resp_valid !== 1'b0) begin errors++; $display("FAIL rstwait_inwait: got %b exp 0", b2.resp_valid); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        pw_m[0] = 0; pw_m[1] = 0; done_m[0] = 0; done_m[1] = 0;
        #1;
        checks++; if (b2.req_ready !== 1'b1) begin errors++; $display("FAIL rstwait_ready: got %b exp 1", b2.req_ready); end
        checks++; if (pw2 !== 9'(pw_m[0]) || done2 !== 1'b0) begin errors++;
            $display("FAIL rstwait_state: got pw %0d done %b exp pw %0d done 0", pw2, done2, pw_m[0]); end
        seen = 0;
        repeat (5) begin @(posedge clk); #1; if (b2.resp_valid) seen = 1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstwait_no_resp: got %b exp 0", seen); end
        nd = $urandom;
        load2(1, nd);
        model_read(0, 32'h0, ei, ee, el);
        fetch2(32'h0, ins, e, l, lat);
        checks++; if ({ins, e, l} !== {ei, ee, el} || lat !== 2) begin errors++;
            $display("FAIL rstwait_mem_kept: got %h/%b/%b lat %0d exp %h/%b/%b lat 2", ins, e, l, lat, ei, ee, el); end
    endtask

    task automatic test_latency1();
        logic [31:0] ei, nd; logic ee, el;
        for (int i = 0; i < 4; i++) load1(i, prog[i]);
        checks++; if (pw1 !== 9'(pw_m[1])) begin errors++; $display("FAIL l1_prog_words: got %0d exp %0d", pw1, pw_m[1]); end
        b1.resp_ready = 1'b1; b1.req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b1.req_addr = 32'(i * 4);
            #1;
            checks++; if (b1.req_ready !== 1'b1) begin errors++; $display("FAIL l1_ready[%0d]: got %b exp 1", i, b1.req_ready); end
            model_read(1, 32'(i * 4), ei, ee, el);
            @(posedge clk); #1;
            checks++; if ({b1.resp_valid, b1.req_ready, b1.resp_instr, b1.resp_err, b1.resp_last} !== {1'b1, 1'b0, ei, ee, el}) begin errors++;
                $display("FAIL l1_resp[%0d]: got v%b r%b %h/%b/%b exp v1 r0 %h/%b/%b", i, b1.resp_valid, b1.req_ready,
                         b1.resp_instr, b1.resp_err, b1.resp_last, ei, ee, el); end
            if (el) done_m[1] = 1;
            @(posedge clk); #1;
            checks++; if (b1.resp_valid !== 1'b0) begin errors++; $display("FAIL l1_gap[%0d]: got %b exp 0", i, b1.resp_valid); end
        end
        nd = $urandom;
        b1.req_addr = 32'h10;
        ld_en1 = 1'b1; ld_addr1 = 8'd4; ld_data1 = nd;
        #1;
        checks++; if (b1.req_ready !== 1'b0) begin errors++; $display("FAIL l1_load_block: got %b exp 0", b1.req_ready); end
        @(posedge clk); #1;
        ld_en1 = 1'b0;
        model_load(1, 4, nd);
        #1;
        checks++; if (b1.resp_valid !== 1'b0 || b1.req_ready !== 1'b1) begin errors++;
            $display("FAIL l1_load_delay: got v%b r%b exp v0 r1", b1.resp_valid, b1.req_ready); end
        model_read(1, 32'h10, ei, ee, el);
        @(posedge clk); #1;
        b1.req_valid = 1'b0;
        checks++; if ({b1.resp_valid, b1.resp_instr, b1.resp_err, b1.resp_last} !== {1'b1, ei, ee, el}) begin errors++;
            $display("FAIL l1_after_load: got v%b %h/%b/%b exp v1 %h/%b/%b", b1.resp_valid, b1.resp_instr,
                     b1.resp_err, b1.resp_last, ei, ee, el); end
        if (el) done_m[1] = 1;
        @(posedge clk); #1;
        b1.resp_ready = 1'b0;
        checks++; if (done1 !== done_m[1] || pw1 !== 9'(pw_m[1])) begin errors++;
            $display("FAIL l1_done: got done %b pw %0d exp done %b pw %0d", done1, pw1, done_m[1], pw_m[1]); end
    endtask

    task automatic test_random();
        logic [31:0] a, ei, ld_d; logic ee, el; int kind, stall, lw, cap, ld_i, w;
        for (int it = 0; it < 60; it++) begin
            cap = (pw_m[0] < 15) ? pw_m[0] : 15;
            if ($urandom_range(0, 3) == 0) begin
                load2($urandom_range(0, cap), $urandom);
                checks++; if (pw2 !== 9'(pw_m[0])) begin errors++;
                    $display("FAIL rand_load_pw[%0d]: got %0d exp %0d", it, pw2, pw_m[0]); end
            end else begin
                kind = $urandom_range(0, 3);
                w = (pw_m[0] > 0) ? $urandom_range(0, pw_m[0] - 1) : 0;
                case (kind)
                    0: a = 32'(w * 4);
                    1: a = 32'((pw_m[0] + $urandom_range(0, 2)) * 4);
                    2: a = 32'(w * 4 + $urandom_range(1, 3));
                    default: a = $urandom;
                endcase
                stall = $urandom_range(0, 3);
                lw = $urandom_range(0, 2);
                ld_i = $urandom_range(0, cap);
                ld_d = $urandom;
                b2.req_valid = 1'b1; b2.req_addr = a; b2.resp_ready = 1'b0;
                #1;
                checks++; if (b2.req_ready !== 1'b1) begin errors++; $display("FAIL rand_ready[%0d]: got %b exp 1", it, b2.req_ready); end
                @(posedge clk); #1;
                b2.req_valid = 1'b0;
                if (lw == 1) begin ld_en2 = 1'b1; ld_addr2 = 8'(ld_i); ld_data2 = ld_d; end
                @(posedge clk); #1;
                if (lw == 1) begin ld_en2 = 1'b0; model_load(0, ld_i, ld_d); end
                checks++; if (b2.resp_valid !== 1'b0) begin errors++; $display("FAIL rand_early[%0d]: got %b exp 0", it, b2.resp_valid); end
                if (lw == 2) begin ld_en2 = 1'b1; ld_addr2 = 8'(ld_i); ld_data2 = ld_d; end
                // The read sees memory and length as they stand before this edge's write.
                model_read(0, a, ei, ee, el);
                @(posedge clk); #1;
                if (lw == 2) begin ld_en2 = 1'b0; model_load(0, ld_i, ld_d); end
                checks++; if ({b2.resp_valid, b2.resp_instr, b2.resp_err, b2.resp_last} !== {1'b1, ei, ee, el}) begin errors++;
                    $display("FAIL rand_resp[%0d]: addr %h got v%b %h/%b/%b exp v1 %h/%b/%b", it, a, b2.resp_valid,
                             b2.resp_instr, b2.resp_err, b2.resp_last, ei, ee, el); end
                for (int s = 0; s < stall; s++) begin
                    @(posedge clk); #1;
                    checks++; if ({b2.resp_valid, b2.req_ready, b2.resp_instr} !== {1'b1, 1'b0, ei}) begin errors++;
                        $display("FAIL rand_hold[%0d]: got v%b r%b %h exp v1 r0 %h", it, b2.resp_valid, b2.req_ready, b2.resp_instr, ei); end
                end
                b2.resp_ready = 1'b1;
                @(posedge clk); #1;
                b2.resp_ready = 1'b0;
                if (el) done_m[0] = 1;
                checks++; if (done2 !== done_m[0] || pw2 !== 9'(pw_m[0])) begin errors++;
                    $display("FAIL rand_state[%0d]: got done %b pw %0d exp done %b pw %0d", it, done2, pw2, done_m[0], pw_m[0]); end
            end
        end
    endtask

    initial begin
        prog[0] = 32'h00500093; prog[1] = 32'h00A00113; prog[2] = 32'h002081B3; prog[3] = 32'h00000013;
        b2.req_valid = 1'b0; b2.req_addr = '0; b2.resp_ready = 1'b0;
        b1.req_valid = 1'b0; b1.req_addr = '0; b1.resp_ready = 1'b0;
        ld_en2 = 1'b0; ld_addr2 = '0; ld_data2 = '0;
        ld_en1 = 1'b0; ld_addr1 = '0; ld_data1 = '0;
        test_reset();
        test_load();
        test_misaligned();
        test_out_of_range();
        test_program();
        test_stall();
        test_reset_in_wait();
        test_latency1();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
